// File: rtl/phase_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sel_sequencer
// Description : Sequences the phase select of a 32-deep SRL delay tap. Phase
//               changes are applied only at 32-cycle frame boundaries, either
//               as a single jump or one step per frame along the shortest
//               path. After the last update the block waits a configurable
//               number of frame boundaries before pulsing done.
// Ports       : clk_in    - sole clock, rising edge
//               reset     - synchronous, active-high
//               req_valid - request valid (accepted only while req_ready)
//               req_phase - target phase 0..31
//               req_mode  - 0 = jump, 1 = step one phase per frame
//               abort     - cancel the request in progress
//               req_ready - idle, able to accept a request
//               phase_sel - registered phase select
//               frame_cnt - free-running position in the 32-cycle frame
//               busy      - request in progress
//               done      - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sel_sequencer #(
    parameter logic [4:0] PHASE_INIT    = 5'd0,
    parameter int         SETTLE_FRAMES = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [4:0] req_phase,
    input  logic       req_mode,
    input  logic       abort,
    output logic       req_ready,
    output logic [4:0] phase_sel,
    output logic [4:0] frame_cnt,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] c_settle_frames = 4'(SETTLE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_JUMP   = 2'd1,
        S_STEP   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [4:0] r_phase_sel;
    logic [4:0] w_phase_next;
    logic [4:0] r_frame_cnt;
    logic [3:0] r_settle_cnt;
    logic [4:0] r_target;
    logic       w_boundary;
    logic       w_accept;
    logic [4:0] w_fwd_dist;
    logic [4:0] w_step_phase;
    logic       w_done;

    assign w_boundary = (r_frame_cnt == 5'd31);
    assign w_accept   = (r_state == S_IDLE) && req_valid;

    // Forward distance mod 32; a tie at 16 resolves to incrementing.
    assign w_fwd_dist   = r_target - r_phase_sel;
    assign w_step_phase = ((w_fwd_dist >= 5'd1) && (w_fwd_dist <= 5'd16))
                        ? (r_phase_sel + 5'd1) : (r_phase_sel - 5'd1);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phase_sel  <= PHASE_INIT;
            r_frame_cnt  <= 5'd0;
            r_settle_cnt <= 4'd0;
            r_target     <= 5'd0;
        end else begin
            r_state     <= w_next_state;
            r_phase_sel <= w_phase_next;
            r_frame_cnt <= r_frame_cnt + 5'd1;
            // The mode is not stored separately: it is encoded by the
            // choice of JUMP or STEP made at acceptance.
            if (w_accept) begin
                r_target <= req_phase;
            end
            // Held at zero outside SETTLE so it is clear on entry.
            if (r_state != S_SETTLE) begin
                r_settle_cnt <= 4'd0;
            end else if (w_boundary) begin
                r_settle_cnt <= r_settle_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_phase_next = r_phase_sel;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // No update here, so an acceptance on a boundary cycle
                // defers the first phase change to the next boundary.
                if (req_valid) begin
                    if (req_phase == r_phase_sel) begin
                        w_next_state = S_SETTLE;
                    end else if (req_mode) begin
                        w_next_state = S_STEP;
                    end else begin
                        w_next_state = S_JUMP;
                    end
                end
            end
            S_JUMP: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_boundary) begin
                    w_phase_next = r_target;
                    w_next_state = S_SETTLE;
                end
            end
            S_STEP: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_boundary) begin
                    w_phase_next = w_step_phase;
                    if (w_step_phase == r_target) begin
                        w_next_state = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (r_settle_cnt == c_settle_frames) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = w_done;
    assign phase_sel = r_phase_sel;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_phase_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sel_sequencer
// Description : Directed testbench for phase_sel_sequencer (defaults:
//               PHASE_INIT = 0, SETTLE_FRAMES = 2). Inputs are driven and
//               outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sel_sequencer;

    logic       clk_in    = 1'b0;
    logic       reset     = 1'b1;
    logic       req_valid = 1'b0;
    logic [4:0] req_phase = 5'd0;
    logic       req_mode  = 1'b0;
    logic       abort     = 1'b0;
    logic       req_ready;
    logic [4:0] phase_sel;
    logic [4:0] frame_cnt;
    logic       busy;
    logic       done;

    int errors    = 0;
    int checks    = 0;
    int done_seen = 0;

    phase_sel_sequencer #(
        .PHASE_INIT    (5'd0),
        .SETTLE_FRAMES (2)
    ) u_dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .req_valid (req_valid),
        .req_phase (req_phase),
        .req_mode  (req_mode),
        .abort     (abort),
        .req_ready (req_ready),
        .phase_sel (phase_sel),
        .frame_cnt (frame_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (done === 1'b1) done_seen++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_frame(input logic [4:0] f);
        int k = 0;
        while (frame_cnt !== f && k < 40) begin
            step(1);
            k++;
        end
        checks++;
        if (frame_cnt !== f) begin
            errors++;
            $display("FAIL wait_frame: frame_cnt=%0d required=%0d", frame_cnt, f);
        end
    endtask

    // Advance to the next cycle with frame_cnt == 0 (at least one cycle on).
    task automatic next_frame0();
        step(1);
        wait_frame(5'd0);
    endtask

    task automatic issue(input logic [4:0] p, input logic m);
        req_valid = 1'b1;
        req_phase = p;
        req_mode  = m;
        step(1);
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept: busy=%b req_ready=%b required busy=1 req_ready=0", busy, req_ready);
        end
    endtask

    // exp_cycles == 0 means any latency within the bound is acceptable.
    task automatic wait_done(input int exp_cycles, input string name);
        int n = 0;
        while (n < 200) begin
            step(1);
            n++;
            if (done === 1'b1) break;
        end
        checks++;
        if (done !== 1'b1 || (exp_cycles > 0 && n != exp_cycles)) begin
            errors++;
            $display("FAIL %s done_latency: done=%b after %0d cycles, required done=1 after %0d",
                     name, done, n, exp_cycles);
        end
        step(1);
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b ready=%b busy=%b required 0,1,0",
                     name, done, req_ready, busy);
        end
    endtask

    task automatic do_jump(input logic [4:0] p);
        issue(p, 1'b0);
        wait_done(0, "setup_jump");
        checks++;
        if (phase_sel !== p) begin
            errors++;
            $display("FAIL setup_jump phase: phase_sel=%0d required=%0d", phase_sel, p);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b1;
        req_phase = 5'd9;
        abort     = 1'b1;
        step(2);
        req_valid = 1'b0;
        abort     = 1'b0;
        checks++;
        if (phase_sel !== 5'd0 || frame_cnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_regs: phase_sel=%0d frame_cnt=%0d required 0,0", phase_sel, frame_cnt);
        end
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b ready=%b done=%b required 0,1,0", busy, req_ready, done);
        end
        reset = 1'b0;
        step(1);
        checks++;
        if (frame_cnt !== 5'd1) begin
            errors++;
            $display("FAIL frame_count: frame_cnt=%0d required=1", frame_cnt);
        end
    endtask

    task automatic test_jump();
        wait_frame(5'd5);
        issue(5'd20, 1'b0);
        step(25);
        checks++;
        if (frame_cnt !== 5'd31 || phase_sel !== 5'd0) begin
            errors++;
            $display("FAIL jump_hold: frame_cnt=%0d phase_sel=%0d required 31,0", frame_cnt, phase_sel);
        end
        step(1);
        checks++;
        if (frame_cnt !== 5'd0 || phase_sel !== 5'd20) begin
            errors++;
            $display("FAIL jump_update: frame_cnt=%0d phase_sel=%0d required 0,20", frame_cnt, phase_sel);
        end
        wait_done(64, "jump");
    endtask

    task automatic test_step_wrap();
        logic [4:0] exp_seq [4];
        exp_seq = '{5'd31, 5'd0, 5'd1, 5'd2};
        do_jump(5'd30);
        issue(5'd2, 1'b1);
        // Changing inputs and a request while busy must have no effect.
        req_phase = 5'd9;
        req_mode  = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_frame0();
            checks++;
            if (phase_sel !== exp_seq[k]) begin
                errors++;
                $display("FAIL step_wrap[%0d]: phase_sel=%0d required=%0d", k, phase_sel, exp_seq[k]);
            end
        end
        req_valid = 1'b0;
        wait_done(64, "step_wrap");
    endtask

    task automatic test_tie();
        do_jump(5'd0);
        issue(5'd16, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            next_frame0();
            checks++;
            if (phase_sel !== 5'(k)) begin
                errors++;
                $display("FAIL tie_inc[%0d]: phase_sel=%0d required=%0d", k, phase_sel, k);
            end
        end
        wait_done(64, "tie_inc");
        do_jump(5'd0);
        issue(5'd17, 1'b1);
        for (int k = 0; k < 15; k++) begin
            next_frame0();
            checks++;
            if (phase_sel !== 5'(31 - k)) begin
                errors++;
                $display("FAIL dec[%0d]: phase_sel=%0d required=%0d", k, phase_sel, 31 - k);
            end
        end
        wait_done(64, "dec");
    endtask

    task automatic test_boundary_accept();
        wait_frame(5'd31);
        issue(5'd5, 1'b0);
        checks++;
        if (frame_cnt !== 5'd0 || phase_sel !== 5'd17) begin
            errors++;
            $display("FAIL boundary_no_update: frame_cnt=%0d phase_sel=%0d required 0,17", frame_cnt, phase_sel);
        end
        step(31);
        checks++;
        if (phase_sel !== 5'd17) begin
            errors++;
            $display("FAIL boundary_hold: phase_sel=%0d required=17", phase_sel);
        end
        step(1);
        checks++;
        if (frame_cnt !== 5'd0 || phase_sel !== 5'd5) begin
            errors++;
            $display("FAIL boundary_update: frame_cnt=%0d phase_sel=%0d required 0,5", frame_cnt, phase_sel);
        end
        wait_done(64, "boundary");
    endtask

    task automatic test_abort();
        int d0;
        do_jump(5'd0);
        issue(5'd10, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            next_frame0();
            checks++;
            if (phase_sel !== 5'(k)) begin
                errors++;
                $display("FAIL abort_step[%0d]: phase_sel=%0d required=%0d", k, phase_sel, k);
            end
        end
        step(3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || phase_sel !== 5'd4 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: ready=%b busy=%b phase_sel=%0d done=%b required 1,0,4,0",
                     req_ready, busy, phase_sel, done);
        end
        d0 = done_seen;
        step(70);
        checks++;
        if (phase_sel !== 5'd4 || done_seen != d0) begin
            errors++;
            $display("FAIL abort_quiet: phase_sel=%0d done_pulses=%0d required 4,%0d", phase_sel, done_seen, d0);
        end
        // Abort on a boundary cycle suppresses that cycle's update.
        issue(5'd10, 1'b1);
        wait_frame(5'd31);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++;
        if (phase_sel !== 5'd4 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_boundary: phase_sel=%0d ready=%b required 4,1", phase_sel, req_ready);
        end
        // Request for the current phase: settle only.
        wait_frame(5'd10);
        issue(5'd4, 1'b1);
        wait_done(53, "same_phase");
        checks++;
        if (phase_sel !== 5'd4) begin
            errors++;
            $display("FAIL same_phase: phase_sel=%0d required=4", phase_sel);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        issue(5'd20, 1'b1);
        next_frame0();
        next_frame0();
        checks++;
        if (phase_sel !== 5'd6) begin
            errors++;
            $display("FAIL mid_step: phase_sel=%0d required=6", phase_sel);
        end
        step(7);
        d0 = done_seen;
        reset = 1'b1;
        step(1);
        checks++;
        if (phase_sel !== 5'd0 || frame_cnt !== 5'd0 || busy !== 1'b0 ||
            req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: phase_sel=%0d frame_cnt=%0d busy=%b ready=%b done=%b required 0,0,0,1,0",
                     phase_sel, frame_cnt, busy, req_ready, done);
        end
        reset = 1'b0;
        step(70);
        checks++;
        if (phase_sel !== 5'd0 || busy !== 1'b0 || done_seen != d0) begin
            errors++;
            $display("FAIL reset_discard: phase_sel=%0d busy=%b done_pulses=%0d required 0,0,%0d",
                     phase_sel, busy, done_seen, d0);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_step_wrap();
        test_tie();
        test_boundary_accept();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phase_sel_sequencer.md
PHASE_SEL_SEQUENCER -- requirements
Module: phase_sel_sequencer

Interface
REQ-001 Parameter PHASE_INIT, 5'd0, PHASE_SEL value loaded on reset.
REQ-002 Parameter SETTLE_FRAMES, 2, frame boundaries to wait after the final PHASE_SEL update before DONE (legal 0..15).
REQ-003 CLK_IN  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 REQ_VALID  input  1  phase-change request valid.
REQ-006 REQ_PHASE  input  5  target phase (0..31).
REQ-007 REQ_MODE  input  1  0 = jump directly to target, 1 = step one phase per frame.
REQ-008 ABORT  input  1  cancel the in-progress request.
REQ-009 REQ_READY  output  1  block can accept a request.
REQ-010 PHASE_SEL  output  5  registered phase select driving the 32-deep SRL delay tap.
REQ-011 FRAME_CNT  output  5  free-running position within the 32-cycle clock frame.
REQ-012 BUSY  output  1  request in progress.
REQ-013 DONE  output  1  one-cycle pulse on request completion.

Function
REQ-014 FRAME_CNT SHALL increment by 1 every cycle, wrapping 31->0; a boundary cycle is one with FRAME_CNT==31.
REQ-015 PHASE_SEL SHALL change only on the clock edge that ends a boundary cycle, so every new value first applies in a cycle with FRAME_CNT==0.
REQ-016 FSM states: IDLE, JUMP, STEP, SETTLE; BUSY = (state != IDLE); REQ_READY = (state == IDLE).
REQ-017 IDLE: when REQ_VALID && REQ_READY, latch REQ_PHASE as target and REQ_MODE; next state SETTLE if target == PHASE_SEL, else JUMP (mode 0) or STEP (mode 1).
REQ-018 An acceptance occurring in a boundary cycle SHALL NOT update PHASE_SEL at that edge; the first update is at the next boundary.
REQ-019 JUMP: at the next boundary, PHASE_SEL <= target; next state SETTLE.
REQ-020 STEP: at each boundary, PHASE_SEL moves one step mod 32 in the shortest direction to target (forward distance d = (target - PHASE_SEL) mod 32; increment if 1 <= d <= 16, else decrement); 31+1 wraps to 0 and 0-1 wraps to 31.
REQ-021 STEP: when the updated PHASE_SEL equals target, next state SETTLE; the direction is re-evaluated at every boundary.
REQ-022 SETTLE: a 4-bit counter cleared on entry SHALL count boundary cycles; when the count reaches SETTLE_FRAMES, assert DONE for one cycle and return to IDLE on the same edge.
REQ-023 With SETTLE_FRAMES == 0, DONE SHALL assert in the first cycle spent in SETTLE.
REQ-024 ABORT in JUMP, STEP or SETTLE SHALL return the FSM to IDLE on the next edge; PHASE_SEL holds its current value, DONE is not asserted, and an abort on a boundary cycle suppresses that cycle's PHASE_SEL update.
REQ-025 ABORT SHALL be ignored in IDLE; REQ_VALID SHALL be ignored outside IDLE (no queuing).
REQ-026 The target and mode SHALL be held stable from acceptance to completion regardless of input changes.

Reset
REQ-027 With RESET high at an edge: state = IDLE, PHASE_SEL = PHASE_INIT, FRAME_CNT = 0, settle counter = 0, DONE = 0, BUSY = 0, REQ_READY = 1 in the following cycle.
REQ-028 RESET SHALL take priority over ABORT, REQ_VALID and all in-progress activity, and SHALL discard any pending target.

Verification
REQ-029 Reset, then REQ_PHASE=20 mode 0 accepted at FRAME_CNT=5 -> PHASE_SEL=20 first seen at FRAME_CNT=0; DONE pulses at the end of the 2nd following boundary cycle (SETTLE_FRAMES=2).
REQ-030 PHASE_SEL=30, REQ_PHASE=2 mode 1 -> PHASE_SEL sequence 31,0,1,2, one per frame; then SETTLE, then DONE.
REQ-031 PHASE_SEL=0, REQ_PHASE=16 mode 1 (tie) -> increments 1..16 over 16 frames; REQ_PHASE=17 from 0 -> decrements 31..17 over 15 frames.
REQ-032 Request accepted in a cycle with FRAME_CNT=31 -> no update at that edge; update occurs 32 cycles later.
REQ-033 ABORT during STEP 0->10 after PHASE_SEL=4 -> PHASE_SEL stays 4, no DONE, REQ_READY=1 next cycle; REQ_PHASE equal to current PHASE_SEL -> no PHASE_SEL change, DONE after SETTLE_FRAMES boundaries.
REQ-034 RESET asserted mid-STEP -> next cycle PHASE_SEL=PHASE_INIT, FRAME_CNT=0, BUSY=0, no DONE.
